// File: rtl/control_decoder_sync.sv
// ============================================================================
// control_decoder_sync: synchronised, debounced control-switch decoder
// with a startup qualification phase, a hold mode and a change strobe/mask.
// Revision: 1.0
// ============================================================================
`default_nettype none

module control_decoder_sync #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] control_switches,
  input  logic             hold,
  output logic [WIDTH-1:0] ctrl_word,
  output logic             changed,
  output logic [WIDTH-1:0] changed_mask,
  output logic             valid
);

  localparam logic [CNT_W-1:0] C_DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_START_LAST = CNT_W'(DEBOUNCE_CYCLES + 2);

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sync1, sync2, stable;
  logic [CNT_W-1:0] start_cnt, start_cnt_next;
  logic [WIDTH-1:0] ctrl_word_next, changed_mask_next;
  logic             changed_next, valid_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= control_switches;
      sync2 <= sync1;
    end
  end

  // Each bit debounces independently; a return to the stable value restarts its count.
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic [CNT_W-1:0] cnt;
      logic             stable_bit;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt        <= '0;
          stable_bit <= 1'b0;
        end else if (sync2[i] == stable_bit) begin
          cnt <= '0;
        end else if (cnt == C_DB_LAST) begin
          stable_bit <= sync2[i];
          cnt        <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      assign stable[i] = stable_bit;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= INIT;
      start_cnt    <= '0;
      ctrl_word    <= '0;
      changed      <= 1'b0;
      changed_mask <= '0;
      valid        <= 1'b0;
    end else begin
      state        <= state_next;
      start_cnt    <= start_cnt_next;
      ctrl_word    <= ctrl_word_next;
      changed      <= changed_next;
      changed_mask <= changed_mask_next;
      valid        <= valid_next;
    end
  end

  always_comb begin
    state_next        = state;
    start_cnt_next    = start_cnt;
    ctrl_word_next    = ctrl_word;
    changed_next      = 1'b0;
    changed_mask_next = '0;
    valid_next        = valid;
    case (state)
      INIT: begin
        if (start_cnt == C_START_LAST) begin
          // Initial load is silent: downstream sees valid rise, not a change.
          ctrl_word_next = stable;
          valid_next     = 1'b1;
          state_next     = RUN;
        end else begin
          start_cnt_next = start_cnt + 1'b1;
        end
      end
      RUN: begin
        if (!hold && (stable != ctrl_word)) begin
          ctrl_word_next    = stable;
          changed_next      = 1'b1;
          changed_mask_next = stable ^ ctrl_word;
        end
      end
      default: state_next = INIT;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_control_decoder_sync.sv
// ============================================================================
// tb_control_decoder_sync: directed self-checking bench for control_decoder_sync.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_control_decoder_sync;

  logic       clk;
  logic       rst_n;
  logic [3:0] control_switches;
  logic       hold;
  logic [3:0] ctrl_word;
  logic       changed;
  logic [3:0] changed_mask;
  logic       valid;

  int n_cmp;
  int n_err;

  control_decoder_sync #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (20)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .control_switches(control_switches),
    .hold            (hold),
    .ctrl_word       (ctrl_word),
    .changed         (changed),
    .changed_mask    (changed_mask),
    .valid           (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; outputs are read there too.
  task automatic tick(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] cw, input logic ch,
                           input logic [3:0] mk, input logic vl);
    check({tag, ".ctrl_word"}, 32'(ctrl_word), 32'(cw));
    check({tag, ".changed"}, 32'(changed), 32'(ch));
    check({tag, ".changed_mask"}, 32'(changed_mask), 32'(mk));
    check({tag, ".valid"}, 32'(valid), 32'(vl));
  endtask

  initial begin
    n_cmp            = 0;
    n_err            = 0;
    rst_n            = 1'b0;
    hold             = 1'b0;
    control_switches = 4'b1010;

    // 1: reset, startup qualification, silent initial load
    tick(2);
    check_out("reset", 4'b0000, 1'b0, 4'b0000, 1'b0);
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick(1);
      check_out($sformatf("init_e%0d", e), 4'b0000, 1'b0, 4'b0000, 1'b0);
    end
    tick(1);
    check_out("init_load", 4'b1010, 1'b0, 4'b0000, 1'b1);
    tick(1);
    check_out("init_after", 4'b1010, 1'b0, 4'b0000, 1'b1);

    // bring ctrl_word to 0000
    control_switches = 4'b0000;
    tick(6);
    check_out("clr_before", 4'b1010, 1'b0, 4'b0000, 1'b1);
    tick(1);
    check_out("clr_pulse", 4'b0000, 1'b1, 4'b1010, 1'b1);
    tick(1);
    check_out("clr_after", 4'b0000, 1'b0, 4'b0000, 1'b1);

    // 2: 0000 -> 0101, six-edge latency, single pulse
    control_switches = 4'b0101;
    tick(6);
    check_out("lat_before", 4'b0000, 1'b0, 4'b0000, 1'b1);
    tick(1);
    check_out("lat_pulse", 4'b0101, 1'b1, 4'b0101, 1'b1);
    tick(1);
    check_out("lat_after", 4'b0101, 1'b0, 4'b0000, 1'b1);
    control_switches = 4'b0000;
    tick(7);
    check_out("back0_pulse", 4'b0000, 1'b1, 4'b0101, 1'b1);
    tick(1);

    // 3: three-cycle glitch is rejected
    control_switches = 4'b0001;
    tick(3);
    control_switches = 4'b0000;
    for (int e = 0; e < 10; e++) begin
      tick(1);
      check_out($sformatf("glitch_%0d", e), 4'b0000, 1'b0, 4'b0000, 1'b1);
    end

    // 4: hold freezes ctrl_word; release delivers net change once
    hold             = 1'b1;
    control_switches = 4'b1111;
    for (int e = 0; e < 20; e++) begin
      tick(1);
      check($sformatf("hold_changed_%0d", e), 32'(changed), 32'd0);
    end
    check_out("hold_frozen", 4'b0000, 1'b0, 4'b0000, 1'b1);
    hold = 1'b0;
    tick(1);
    check_out("hold_release", 4'b1111, 1'b1, 4'b1111, 1'b1);
    tick(1);
    check_out("hold_after", 4'b1111, 1'b0, 4'b0000, 1'b1);

    // 5: net-zero change under hold produces no pulse
    control_switches = 4'b0000;
    tick(7);
    check_out("nz_setup", 4'b0000, 1'b1, 4'b1111, 1'b1);
    tick(1);
    hold             = 1'b1;
    control_switches = 4'b0010;
    tick(10);
    control_switches = 4'b0000;
    tick(10);
    check_out("nz_held", 4'b0000, 1'b0, 4'b0000, 1'b1);
    hold = 1'b0;
    tick(1);
    check_out("nz_release", 4'b0000, 1'b0, 4'b0000, 1'b1);
    tick(1);
    check_out("nz_after", 4'b0000, 1'b0, 4'b0000, 1'b1);

    // 6: reset mid-operation with a debounce in flight
    control_switches = 4'b1111;
    tick(7);
    check_out("mr_setup", 4'b1111, 1'b1, 4'b1111, 1'b1);
    tick(1);
    control_switches = 4'b0000;
    tick(3);
    rst_n = 1'b0;
    tick(1);
    check_out("mr_reset", 4'b0000, 1'b0, 4'b0000, 1'b0);
    rst_n            = 1'b1;
    control_switches = 4'b0110;
    for (int e = 1; e <= 6; e++) begin
      tick(1);
      check_out($sformatf("mr_init_e%0d", e), 4'b0000, 1'b0, 4'b0000, 1'b0);
    end
    tick(1);
    check_out("mr_load", 4'b0110, 1'b0, 4'b0000, 1'b1);
    tick(1);
    check_out("mr_after", 4'b0110, 1'b0, 4'b0000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/control_decoder_sync.md
Name: control_decoder_sync

Overview:
Parametrised successor to the lab's combinational control-switch decoder. Takes WIDTH raw board control switches, synchronises and debounces each bit, and presents a registered control word to downstream datapath logic (shift/ALU mode selects). Adds a startup qualification phase, a hold/freeze mode, and a one-cycle change strobe with a per-bit change mask.

Parameters:
WIDTH, 4, number of control switch bits
DEBOUNCE_CYCLES, 4, consecutive clock cycles a synchronised bit must differ from its stable value before it is accepted (board build overrides, e.g. 1_000_000); minimum 2
CNT_W, 20, debounce counter width; must hold DEBOUNCE_CYCLES+2

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  reset, synchronous, active-low
control_switches  input  WIDTH  raw asynchronous switch inputs
hold  input  1  1 = freeze ctrl_word; debouncing continues underneath
ctrl_word  output  WIDTH  registered debounced control word
changed  output  1  one-cycle pulse when ctrl_word changes value
changed_mask  output  WIDTH  bits of ctrl_word that toggled; valid only while changed=1, else 0
valid  output  1  0 during startup qualification, 1 once ctrl_word is trustworthy

Behaviour:
- Reset (rst_n=0 at a rising edge): synchronisers, stable bits, all per-bit counters, startup counter cleared; ctrl_word=0, changed=0, changed_mask=0, valid=0; state=INIT. Reset asserted mid-operation takes effect at that edge regardless of debounce or hold state.
- Synchroniser: two flops per bit (sync1, sync2); no logic between them.
- Debounce, per bit i independently: if sync2[i]==stable[i], cnt[i]<=0. Else if cnt[i]==DEBOUNCE_CYCLES-1, stable[i]<=sync2[i] and cnt[i]<=0. Else cnt[i]<=cnt[i]+1. A mismatch lasting fewer than DEBOUNCE_CYCLES cycles never reaches stable; a return to the stable value resets that bit's count.
- State machine:
  INIT: startup counter increments every cycle; ctrl_word=0, valid=0, changed=0. When count reaches DEBOUNCE_CYCLES+2, ctrl_word<=stable, valid<=1, go to RUN. This initial load raises no changed pulse.
  RUN: if hold=0 and stable!=ctrl_word, ctrl_word<=stable, changed<=1, changed_mask<=stable^ctrl_word (registered together). Otherwise changed<=0, changed_mask<=0. If hold=1, ctrl_word is frozen; when hold drops, any pending difference loads on the next edge with one changed pulse whose mask covers every bit that differs (net change, not history).
  RUN returns to INIT only through reset.
- Latency (RUN, hold=0): if new switch value is first sampled by sync1 at edge k and stays stable, stable updates at edge k+1+DEBOUNCE_CYCLES, and ctrl_word/changed update at edge k+2+DEBOUNCE_CYCLES. With default 4: 6 edges.
- Multiple bits changing at different times: each bit is accepted independently; if two bits are accepted on the same edge, one changed pulse carries both mask bits; if accepted on different edges, separate pulses.
- Back-to-back changes: changed may be high on consecutive cycles when successive bits are accepted on consecutive edges.
- ctrl_word is never combinationally derived from control_switches.

Test Plan:
1. Reset then release with control_switches=4'b1010 held: valid=0 and ctrl_word=0 through INIT; valid=1 and ctrl_word=1010 after DEBOUNCE_CYCLES+2 cycles; changed never pulses.
2. In RUN, ctrl_word=0000, set switches to 0101 (first sampled at edge k): ctrl_word=0101 at edge k+6, changed=1 with changed_mask=0101 for exactly one cycle.
3. Glitch: switches 0000 -> 0001 for 3 cycles -> 0000: ctrl_word stays 0000, changed never asserts.
4. Hold: assert hold, change switches 0000 -> 1111 and wait 20 cycles: ctrl_word stays 0000, changed=0; drop hold: next edge ctrl_word=1111, changed=1, changed_mask=1111 once.
5. Hold net-zero: hold=1, switches 0000 -> 0010 (accepted) -> 0000 (accepted), drop hold: no changed pulse, ctrl_word=0000.
6. Reset mid-operation: in RUN with ctrl_word=1111 and a debounce in progress, rst_n=0 for one edge: ctrl_word=0, valid=0, changed=0 at that edge; INIT repeats after release.
